// File: rtl/gray_tile_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// gray_seq_pkg
// Shared types and constants for the gray tile sequencer slice.
//   gray_seq_state_t : sequencer FSM states
//   PIX_W / WORD_W   : RGB444 pixel width and packed 3-pixel RAM word width
//   rgb_word_t       : one RAM word, pixel 0 in bits [11:0]
//   gray_of()        : per-pixel luma, (5R + 9G + 2B) >> 4
// ---------------------------------------------------------------------------
package gray_seq_pkg;

    localparam int PIX_W  = 12;
    localparam int WORD_W = 36;

    typedef logic [WORD_W-1:0] rgb_word_t;

    typedef enum logic [2:0] {
        IDLE,
        RD0,
        RD1,
        RD2,
        RDW,
        WR0,
        WR1,
        WR2
    } gray_seq_state_t;

    // The weighted sum peaks at 16*15 = 240, so 8 bits never overflow and
    // the shifted result always fits a 4-bit gray level.
    function automatic logic [3:0] gray_of(input logic [PIX_W-1:0] pix);
        logic [7:0] sum;
        sum = 8'd5 * {4'b0000, pix[11:8]}
            + 8'd9 * {4'b0000, pix[7:4]}
            + 8'd2 * {4'b0000, pix[3:0]};
        return 4'(sum >> 4);
    endfunction

endpackage

// File: rtl/gray_tile_sequencer_if.sv
// ---------------------------------------------------------------------------
// gray_tile_sequencer_if
// Pixel RAM port bundle between the sequencer and the RAM.
//   rd_en / rd_addr   : read strobe and word address (sequencer -> RAM)
//   rd_data           : read word, valid one cycle after rd_en (RAM -> sequencer)
//   wr_en / wr_addr / wr_data : write request (sequencer -> RAM)
//   wr_ready          : write accepted when wr_en && wr_ready (RAM -> sequencer)
// Modports: master (sequencer side), slave (RAM side).
// ---------------------------------------------------------------------------
interface gray_tile_sequencer_if
    import gray_seq_pkg::*;
#(
    parameter int ADDR_W = 16
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    rgb_word_t         rd_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    rgb_word_t         wr_data;
    logic              wr_ready;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data,
        input  rd_data, wr_ready
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
        output rd_data, wr_ready
    );
endinterface

// File: rtl/gray_tile_sequencer_gray_converter.sv
// ---------------------------------------------------------------------------
// gray_converter
// Purely combinational RGB444 -> gray datapath over one 3x3 tile window.
// Each output pixel carries its gray level replicated into R, G and B.
//   row0_in..row2_in   : window rows (3 packed pixels each)
//   row0_out..row2_out : converted rows
// ---------------------------------------------------------------------------
module gray_converter
    import gray_seq_pkg::*;
(
    input  rgb_word_t row0_in,
    input  rgb_word_t row1_in,
    input  rgb_word_t row2_in,
    output rgb_word_t row0_out,
    output rgb_word_t row1_out,
    output rgb_word_t row2_out
);

    function automatic rgb_word_t convert_word(input rgb_word_t w);
        rgb_word_t  r;
        logic [3:0] g;
        r = '0;
        for (int p = 0; p < 3; p++) begin
            g = gray_of(w[p*PIX_W +: PIX_W]);
            r[p*PIX_W +: PIX_W] = {g, g, g};
        end
        return r;
    endfunction

    assign row0_out = convert_word(row0_in);
    assign row1_out = convert_word(row1_in);
    assign row2_out = convert_word(row2_in);

endmodule

// File: rtl/gray_tile_sequencer.sv
// ---------------------------------------------------------------------------
// gray_tile_sequencer
// Walks an RGB444 image in pixel RAM as 3x3 tiles in raster order. For each
// tile it reads three row words, converts them through gray_converter and
// writes the three converted words to the destination buffer.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start, abort        : one-cycle requests to run / cancel an image
//   src_base, dst_base  : image word addresses, latched on accepted start
//   busy                : conversion in progress
//   done                : pulse in the cycle the last tile's last write is accepted
//   ram                 : pixel RAM port bundle (master side)
//   cycle_cnt           : busy-cycle counter, only when GRAY_SEQ_PERF_EN is defined
// Optional feature macro: GRAY_SEQ_PERF_EN
// ---------------------------------------------------------------------------
module gray_tile_sequencer
    import gray_seq_pkg::*;
#(
    parameter int IMG_W  = 12,
    parameter int IMG_H  = 9,
    parameter int ADDR_W = 16
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_W-1:0]     src_base,
    input  logic [ADDR_W-1:0]     dst_base,
    output logic                  busy,
    output logic                  done,
    gray_tile_sequencer_if.master ram
`ifdef GRAY_SEQ_PERF_EN
    ,
    output logic [31:0]           cycle_cnt
`endif
);

    localparam int WPR       = IMG_W / 3;
    localparam int TILE_ROWS = IMG_H / 3;
    localparam int TC_W      = (WPR > 1) ? $clog2(WPR) : 1;
    localparam int TR_W      = (TILE_ROWS > 1) ? $clog2(TILE_ROWS) : 1;

    localparam logic [ADDR_W-1:0] ROW1_OFF  = ADDR_W'(WPR);
    localparam logic [ADDR_W-1:0] ROW2_OFF  = ADDR_W'(2 * WPR);
    localparam logic [ADDR_W-1:0] TROW_JUMP = ADDR_W'(2 * WPR + 1);
    localparam logic [TC_W-1:0]   TC_LAST   = TC_W'(WPR - 1);
    localparam logic [TR_W-1:0]   TR_LAST   = TR_W'(TILE_ROWS - 1);

    gray_seq_state_t   state;
    logic [TR_W-1:0]   tr;
    logic [TC_W-1:0]   tc;
    logic [ADDR_W-1:0] row_off;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    rgb_word_t         win0, win1, win2;
    rgb_word_t         gray0, gray1, gray2;
    logic              last_tile;
    logic [ADDR_W-1:0] next_off;

    // row_off tracks row 0 of the current tile, i.e. 3*tr*WPR + tc. Moving
    // one tile right adds 1; wrapping to the next tile row skips the two
    // remaining pixel rows of the current tile row, adding 2*WPR + 1.
    assign last_tile = (tr == TR_LAST) && (tc == TC_LAST);
    assign next_off  = (tc == TC_LAST) ? (row_off + TROW_JUMP)
                                       : (row_off + ADDR_W'(1));

    // done is taken from the live handshake so it lands in the same cycle
    // the final write is accepted; an abort in that cycle suppresses it.
    assign done = (state == WR2) && ram.wr_ready && last_tile && !abort;

    gray_converter u_conv (
        .row0_in  (win0),
        .row1_in  (win1),
        .row2_in  (win2),
        .row0_out (gray0),
        .row1_out (gray1),
        .row2_out (gray2)
    );

    // Write data comes straight off the converter, selected by the current
    // write row; the window is all zero after reset so this reads 0 then.
    always_comb begin
        ram.wr_data = gray0;
        case (state)
            WR1:     ram.wr_data = gray1;
            WR2:     ram.wr_data = gray2;
            default: ram.wr_data = gray0;
        endcase
    end

    // Main sequencer. Strobes and addresses are registered, so each is
    // loaded on the transition into the state that presents it. Read data
    // lags rd_en by one cycle, so row k lands in the state after RDk.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            ram.rd_en   <= 1'b0;
            ram.rd_addr <= '0;
            ram.wr_en   <= 1'b0;
            ram.wr_addr <= '0;
            tr          <= '0;
            tc          <= '0;
            row_off     <= '0;
            src_q       <= '0;
            dst_q       <= '0;
            win0        <= '0;
            win1        <= '0;
            win2        <= '0;
        end else if (state == IDLE) begin
            if (start && !abort) begin
                src_q       <= src_base;
                dst_q       <= dst_base;
                tr          <= '0;
                tc          <= '0;
                row_off     <= '0;
                ram.rd_en   <= 1'b1;
                ram.rd_addr <= src_base;
                busy        <= 1'b1;
                state       <= RD0;
            end
        end else if (abort) begin
            state     <= IDLE;
            busy      <= 1'b0;
            ram.rd_en <= 1'b0;
            ram.wr_en <= 1'b0;
        end else begin
            case (state)
                RD0: begin
                    ram.rd_addr <= src_q + row_off + ROW1_OFF;
                    state       <= RD1;
                end
                RD1: begin
                    win0        <= ram.rd_data;
                    ram.rd_addr <= src_q + row_off + ROW2_OFF;
                    state       <= RD2;
                end
                RD2: begin
                    win1      <= ram.rd_data;
                    ram.rd_en <= 1'b0;
                    state     <= RDW;
                end
                RDW: begin
                    win2        <= ram.rd_data;
                    ram.wr_en   <= 1'b1;
                    ram.wr_addr <= dst_q + row_off;
                    state       <= WR0;
                end
                WR0: begin
                    if (ram.wr_ready) begin
                        ram.wr_addr <= dst_q + row_off + ROW1_OFF;
                        state       <= WR1;
                    end
                end
                WR1: begin
                    if (ram.wr_ready) begin
                        ram.wr_addr <= dst_q + row_off + ROW2_OFF;
                        state       <= WR2;
                    end
                end
                WR2: begin
                    if (ram.wr_ready) begin
                        ram.wr_en <= 1'b0;
                        if (last_tile) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            if (tc == TC_LAST) begin
                                tc <= '0;
                                tr <= tr + TR_W'(1);
                            end else begin
                                tc <= tc + TC_W'(1);
                            end
                            row_off     <= next_off;
                            ram.rd_en   <= 1'b1;
                            ram.rd_addr <= src_q + next_off;
                            state       <= RD0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef GRAY_SEQ_PERF_EN
    // Busy-cycle counter: cleared by an accepted start, counts every busy
    // cycle, saturates at all ones and holds while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt <= '0;
        end else if ((state == IDLE) && start && !abort) begin
            cycle_cnt <= '0;
        end else if (busy && (cycle_cnt != 32'hFFFF_FFFF)) begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_gray_tile_sequencer.sv
// ---------------------------------------------------------------------------
// tb_gray_tile_sequencer
// Directed bench for gray_tile_sequencer. Three instances share one clock,
// reset and source memory: u_small (3x3), u_pair (6x3), u_full (12x9).
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_gray_tile_sequencer;

    logic clk;
    logic rst;

    logic        s_start, s_abort, p_start, p_abort, f_start, f_abort;
    logic [15:0] s_src, s_dst, p_src, p_dst, f_src, f_dst;
    logic        s_busy, s_done, p_busy, p_done, f_busy, f_done;
`ifdef GRAY_SEQ_PERF_EN
    logic [31:0] s_cnt, p_cnt, f_cnt;
`endif

    logic [35:0] mem [256];

    int check_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;

    logic [15:0] p_exp_rd [6] = '{16'h0010, 16'h0012, 16'h0014, 16'h0011, 16'h0013, 16'h0015};
    logic [15:0] p_exp_wr [6] = '{16'h0040, 16'h0042, 16'h0044, 16'h0041, 16'h0043, 16'h0045};
    logic [35:0] p_exp_wd [6] = '{36'h000000FFF, 36'h000444000, 36'h888000000,
                                  36'h111000000, 36'h000000222, 36'h111444777};

    gray_tile_sequencer_if #(.ADDR_W(16)) s_ram ();
    gray_tile_sequencer_if #(.ADDR_W(16)) p_ram ();
    gray_tile_sequencer_if #(.ADDR_W(16)) f_ram ();

    gray_tile_sequencer #(.IMG_W(3), .IMG_H(3), .ADDR_W(16)) u_small (
        .clk(clk), .rst(rst), .start(s_start), .abort(s_abort),
        .src_base(s_src), .dst_base(s_dst), .busy(s_busy), .done(s_done),
        .ram(s_ram)
`ifdef GRAY_SEQ_PERF_EN
        , .cycle_cnt(s_cnt)
`endif
    );

    gray_tile_sequencer #(.IMG_W(6), .IMG_H(3), .ADDR_W(16)) u_pair (
        .clk(clk), .rst(rst), .start(p_start), .abort(p_abort),
        .src_base(p_src), .dst_base(p_dst), .busy(p_busy), .done(p_done),
        .ram(p_ram)
`ifdef GRAY_SEQ_PERF_EN
        , .cycle_cnt(p_cnt)
`endif
    );

    gray_tile_sequencer #(.IMG_W(12), .IMG_H(9), .ADDR_W(16)) u_full (
        .clk(clk), .rst(rst), .start(f_start), .abort(f_abort),
        .src_base(f_src), .dst_base(f_dst), .busy(f_busy), .done(f_done),
        .ram(f_ram)
`ifdef GRAY_SEQ_PERF_EN
        , .cycle_cnt(f_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM model: one-cycle read latency, no backpressure on reads.
    always @(posedge clk) begin
        if (s_ram.rd_en) s_ram.rd_data <= mem[s_ram.rd_addr[7:0]];
        if (p_ram.rd_en) p_ram.rd_data <= mem[p_ram.rd_addr[7:0]];
        if (f_ram.rd_en) f_ram.rd_data <= mem[f_ram.rd_addr[7:0]];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pulse start/abort on one instance (0 small, 1 pair, 2 full) for one cycle.
    task automatic applyStimulus(input int which, input logic st, input logic ab);
        case (which)
            0:       begin s_start = st; s_abort = ab; end
            1:       begin p_start = st; p_abort = ab; end
            default: begin f_start = st; f_abort = ab; end
        endcase
        tick();
        s_start = 1'b0; s_abort = 1'b0;
        p_start = 1'b0; p_abort = 1'b0;
        f_start = 1'b0; f_abort = 1'b0;
    endtask

    initial begin
        int act;
        int done_c;

        for (int i = 0; i < 256; i++) mem[i] = 36'h0;
        mem[8'h00] = 36'hFFFFFFFFF;
        mem[8'h01] = 36'hFFFFFFFFF;
        mem[8'h02] = 36'hFFFFFFFFF;
        mem[8'h10] = 36'h000000FFF;
        mem[8'h12] = 36'h000F00000;
        mem[8'h14] = 36'h0F0000000;
        mem[8'h11] = 36'h00F000000;
        mem[8'h13] = 36'h000000800;
        mem[8'h15] = 36'h123456789;
        mem[8'h21] = 36'h000000800;
        mem[8'hA3] = 36'hFFF000800;

        rst = 1'b1;
        s_start = 1'b0; s_abort = 1'b0; s_src = '0; s_dst = '0;
        p_start = 1'b0; p_abort = 1'b0; p_src = '0; p_dst = '0;
        f_start = 1'b0; f_abort = 1'b0; f_src = '0; f_dst = '0;
        s_ram.wr_ready = 1'b1;
        p_ram.wr_ready = 1'b1;
        f_ram.wr_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        checkOutput("rst_busy",    s_busy, 1'b0);
        checkOutput("rst_done",    s_done, 1'b0);
        checkOutput("rst_rd_en",   s_ram.rd_en, 1'b0);
        checkOutput("rst_wr_en",   s_ram.wr_en, 1'b0);
        checkOutput("rst_rd_addr", s_ram.rd_addr, 16'h0);
        checkOutput("rst_wr_addr", s_ram.wr_addr, 16'h0);
        checkOutput("rst_wr_data", s_ram.wr_data, 36'h0);
        checkOutput("rst_full_busy", f_busy, 1'b0);

        // Test 1: single 3x3 tile of white pixels
        $display("[TB] test 1: 1x1-tile image");
        s_src = 16'h0000; s_dst = 16'h0008;
        applyStimulus(0, 1'b1, 1'b0);
        for (int c = 1; c <= 7; c++) begin
            checkOutput($sformatf("t1_busy_c%0d", c), s_busy, 1'b1);
            if (c <= 3) begin
                checkOutput($sformatf("t1_rd_en_c%0d", c), s_ram.rd_en, 1'b1);
                checkOutput($sformatf("t1_rd_addr_c%0d", c), s_ram.rd_addr, 64'(c - 1));
            end
            if (c >= 5) begin
                checkOutput($sformatf("t1_wr_en_c%0d", c), s_ram.wr_en, 1'b1);
                checkOutput($sformatf("t1_wr_addr_c%0d", c), s_ram.wr_addr, 64'(8 + c - 5));
                checkOutput($sformatf("t1_wr_data_c%0d", c), s_ram.wr_data, 36'hFFFFFFFFF);
            end
            checkOutput($sformatf("t1_done_c%0d", c), s_done, (c == 7));
            tick();
        end
        checkOutput("t1_busy_after", s_busy, 1'b0);
        checkOutput("t1_done_after", s_done, 1'b0);
        checkOutput("t1_wr_en_after", s_ram.wr_en, 1'b0);

        // Test 2: 6x3 image, two tiles, address ordering and conversion
        $display("[TB] test 2: 6x3 image");
        p_src = 16'h0010; p_dst = 16'h0040;
        applyStimulus(1, 1'b1, 1'b0);
        for (int c = 1; c <= 14; c++) begin
            int tile;
            int ph;
            tile = (c - 1) / 7;
            ph   = (c - 1) % 7;
            checkOutput($sformatf("t2_busy_c%0d", c), p_busy, 1'b1);
            checkOutput($sformatf("t2_rd_en_c%0d", c), p_ram.rd_en, (ph < 3));
            checkOutput($sformatf("t2_wr_en_c%0d", c), p_ram.wr_en, (ph > 3));
            if (ph < 3)
                checkOutput($sformatf("t2_rd_addr_c%0d", c), p_ram.rd_addr, p_exp_rd[tile*3 + ph]);
            if (ph > 3) begin
                checkOutput($sformatf("t2_wr_addr_c%0d", c), p_ram.wr_addr, p_exp_wr[tile*3 + ph - 4]);
                checkOutput($sformatf("t2_wr_data_c%0d", c), p_ram.wr_data, p_exp_wd[tile*3 + ph - 4]);
            end
            checkOutput($sformatf("t2_done_c%0d", c), p_done, (c == 14));
            tick();
        end
        checkOutput("t2_busy_after", p_busy, 1'b0);
`ifdef GRAY_SEQ_PERF_EN
        checkOutput("t6_cnt_after_done", p_cnt, 32'd14);
        repeat (3) tick();
        checkOutput("t6_cnt_held", p_cnt, 32'd14);
`endif

        // Test 3: write backpressure in WR1
        $display("[TB] test 3: wr_ready stall");
        s_src = 16'h0020; s_dst = 16'h0030;
        applyStimulus(0, 1'b1, 1'b0);
        repeat (4) tick();
        checkOutput("t3_wr0_addr", s_ram.wr_addr, 16'h0030);
        checkOutput("t3_wr0_data", s_ram.wr_data, 36'h0);
        tick();
        s_ram.wr_ready = 1'b0;
        checkOutput("t3_wr1_addr_c6", s_ram.wr_addr, 16'h0031);
        for (int h = 0; h < 3; h++) begin
            tick();
            checkOutput($sformatf("t3_hold_wr_en_%0d", h), s_ram.wr_en, 1'b1);
            checkOutput($sformatf("t3_hold_addr_%0d", h), s_ram.wr_addr, 16'h0031);
            checkOutput($sformatf("t3_hold_data_%0d", h), s_ram.wr_data, 36'h000000222);
            checkOutput($sformatf("t3_hold_done_%0d", h), s_done, 1'b0);
        end
        s_ram.wr_ready = 1'b1;
        tick();
        checkOutput("t3_wr2_addr", s_ram.wr_addr, 16'h0032);
        checkOutput("t3_wr2_data", s_ram.wr_data, 36'h0);
        checkOutput("t3_done_c10", s_done, 1'b1);
        tick();
        checkOutput("t3_busy_after", s_busy, 1'b0);

        // Test 4: abort during RD2 of tile index 2, then a full restart
        $display("[TB] test 4: abort and restart");
        f_src = 16'h0080; f_dst = 16'h00C0;
        applyStimulus(2, 1'b1, 1'b0);
        repeat (16) tick();
        checkOutput("t4_rd2_en", f_ram.rd_en, 1'b1);
        checkOutput("t4_rd2_addr", f_ram.rd_addr, 16'h008A);
        applyStimulus(2, 1'b0, 1'b1);
        checkOutput("t4_abort_busy", f_busy, 1'b0);
        checkOutput("t4_abort_rd_en", f_ram.rd_en, 1'b0);
        checkOutput("t4_abort_wr_en", f_ram.wr_en, 1'b0);
        checkOutput("t4_abort_done", f_done, 1'b0);
        act = 0;
        for (int i = 0; i < 20; i++) begin
            if (f_ram.rd_en || f_ram.wr_en || f_done || f_busy) act++;
            tick();
        end
        checkOutput("t4_quiet_after_abort", act, 0);
        applyStimulus(2, 1'b1, 1'b0);
        checkOutput("t4_restart_busy", f_busy, 1'b1);
        checkOutput("t4_restart_addr", f_ram.rd_addr, 16'h0080);
        done_c = 0;
        for (int c = 1; c <= 120 && done_c == 0; c++) begin
            if (c == 2)  checkOutput("t4_row1_addr", f_ram.rd_addr, 16'h0084);
            if (c == 3)  checkOutput("t4_row2_addr", f_ram.rd_addr, 16'h0088);
            if (c == 8)  checkOutput("t4_tile1_addr", f_ram.rd_addr, 16'h0081);
            if (c == 29) checkOutput("t4_tilerow1_addr", f_ram.rd_addr, 16'h008C);
            if (f_done) begin
                done_c = c;
                checkOutput("t4_last_wr_addr", f_ram.wr_addr, 16'h00E3);
                checkOutput("t4_last_wr_data", f_ram.wr_data, 36'hFFF000222);
            end else begin
                tick();
            end
        end
        checkOutput("t4_done_cycle", done_c, 84);
        tick();
        checkOutput("t4_busy_after", f_busy, 1'b0);

        // Test 5: start while busy, start+abort in IDLE, reset in WR1
        $display("[TB] test 5: boundary requests");
        applyStimulus(1, 1'b1, 1'b0);
`ifdef GRAY_SEQ_PERF_EN
        checkOutput("t6_cnt_cleared", p_cnt, 32'd0);
`endif
        tick();
        tick();
        applyStimulus(1, 1'b1, 1'b0);
        repeat (4) tick();
        checkOutput("t5_busy_start_tile1", p_ram.rd_addr, 16'h0011);
        repeat (6) tick();
        checkOutput("t5_busy_start_done", p_done, 1'b1);
        tick();
        checkOutput("t5_busy_start_idle", p_busy, 1'b0);

        applyStimulus(1, 1'b1, 1'b1);
        checkOutput("t5_start_abort_busy", p_busy, 1'b0);
        checkOutput("t5_start_abort_rd_en", p_ram.rd_en, 1'b0);
        tick();
        checkOutput("t5_start_abort_busy2", p_busy, 1'b0);

        applyStimulus(1, 1'b1, 1'b0);
        repeat (5) tick();
        checkOutput("t5_wr1_wr_en", p_ram.wr_en, 1'b1);
        checkOutput("t5_wr1_addr", p_ram.wr_addr, 16'h0042);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("t5_rst_busy", p_busy, 1'b0);
        checkOutput("t5_rst_done", p_done, 1'b0);
        checkOutput("t5_rst_rd_en", p_ram.rd_en, 1'b0);
        checkOutput("t5_rst_wr_en", p_ram.wr_en, 1'b0);
        checkOutput("t5_rst_rd_addr", p_ram.rd_addr, 16'h0);
        checkOutput("t5_rst_wr_addr", p_ram.wr_addr, 16'h0);
        checkOutput("t5_rst_wr_data", p_ram.wr_data, 36'h0);
`ifdef GRAY_SEQ_PERF_EN
        checkOutput("t6_rst_cnt", p_cnt, 32'd0);
`endif
        repeat (10) tick();
        checkOutput("t5_no_resume_busy", p_busy, 1'b0);
        checkOutput("t5_no_resume_rd_en", p_ram.rd_en, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
